// File: rtl/tail_light_seq_if.sv
// rtl/tail_light_seq_if.sv - request/lamp bundle between switch inputs, tail_light_seq and LEDR/HEX
//
// Purpose: groups the level requests driven by the switches and keys with the
// lamp, mode and tick outputs of the sequencer.
// Signals:
//   en          prescaler enable (0 freezes sequencing)
//   left_req    left turn request (level)
//   right_req   right turn request (level)
//   hazard_req  hazard request (level)
//   brake       brake pedal (level)
//   left_lamps  left lamps, bit0 innermost
//   right_lamps right lamps, bit0 innermost
//   mode        00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
//   tick        one-cycle step pulse
// Modports: master drives the requests, slave (the sequencer) drives the lamps.

interface tail_light_seq_if #(
    parameter int LAMPS = 3
);
    logic             en;
    logic             left_req;
    logic             right_req;
    logic             hazard_req;
    logic             brake;
    logic [LAMPS-1:0] left_lamps;
    logic [LAMPS-1:0] right_lamps;
    logic [1:0]       mode;
    logic             tick;

    modport master (
        output en, left_req, right_req, hazard_req, brake,
        input  left_lamps, right_lamps, mode, tick
    );

    modport slave (
        input  en, left_req, right_req, hazard_req, brake,
        output left_lamps, right_lamps, mode, tick
    );
endinterface

// File: rtl/tail_light_seq.sv
// rtl/tail_light_seq.sv - sequential tail-light controller with prescaler, sweeps, hazard and brake overlay
//
// Purpose: drives LAMPS lamps per side with left/right sweeps, hazard flashing
// and a brake overlay; steps once every DIV_MAX+1 enabled clocks.
// Ports:
//   ADC_CLK_10  system clock
//   rst         synchronous active-high reset, overrides everything
//   bus         tail_light_seq_if slave: en, left_req, right_req, hazard_req,
//               brake in; left_lamps, right_lamps, mode, tick out (all registered)

module tail_light_seq #(
    parameter int DIV_WIDTH = 5,
    parameter int DIV_MAX   = 31,
    parameter int LAMPS     = 3
) (
    input  logic            ADC_CLK_10,
    input  logic            rst,
    tail_light_seq_if.slave bus
);
    localparam int POS_W = $clog2(LAMPS + 1);
    localparam logic [DIV_WIDTH-1:0] DIV_TC   = DIV_WIDTH'(DIV_MAX);
    localparam logic [POS_W-1:0]     POS_FULL = POS_W'(LAMPS);
    localparam logic [POS_W-1:0]     POS_ONE  = POS_W'(1);
    localparam logic [LAMPS-1:0]     ALL_ON   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LEFT   = 2'b01,
        S_RIGHT  = 2'b10,
        S_HAZARD = 2'b11
    } state_t;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [LAMPS-1:0]     left_q, left_d;
    logic [LAMPS-1:0]     right_q, right_d;
    logic [1:0]           mode_q;
    logic                 tick_q;
    logic                 step;
    logic [LAMPS-1:0]     sweep;

    // Bar-graph pattern: the lowest p lamps lit, i.e. (1<<p)-1.
    function automatic logic [LAMPS-1:0] fill(input logic [POS_W-1:0] p);
        logic [LAMPS-1:0] f;
        f = '0;
        for (int i = 0; i < LAMPS; i++) begin
            f[i] = (POS_W'(i) < p);
        end
        return f;
    endfunction

    // Prescaler and sequencing next state.
    always_comb begin
        step    = bus.en && (cnt_q == DIV_TC);
        cnt_d   = cnt_q;
        state_d = state_q;
        pos_d   = pos_q;

        if (bus.en) begin
            cnt_d = step ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        if (step) begin
            if (pos_q == '0) begin
                // Requests are only looked at between sweeps, so a sweep in
                // flight always completes untouched.
                if (bus.hazard_req || (bus.left_req && bus.right_req)) begin
                    state_d = S_HAZARD;
                    pos_d   = POS_FULL;
                end else if (bus.left_req) begin
                    state_d = S_LEFT;
                    pos_d   = POS_ONE;
                end else if (bus.right_req) begin
                    state_d = S_RIGHT;
                    pos_d   = POS_ONE;
                end else begin
                    state_d = S_IDLE;
                    pos_d   = '0;
                end
            end else if (state_q == S_HAZARD || pos_q == POS_FULL) begin
                // Hazard only ever sits at POS_FULL when non-zero.
                pos_d = '0;
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
        end
    end

    // Lamp images from the current state; brake is sampled every cycle so the
    // overlay keeps working while sequencing is frozen.
    always_comb begin
        sweep   = fill(pos_q);
        left_d  = '0;
        right_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.brake) begin
                    left_d  = ALL_ON;
                    right_d = ALL_ON;
                end
            end
            S_LEFT: begin
                left_d = sweep;
                if (bus.brake) right_d = ALL_ON;
            end
            S_RIGHT: begin
                right_d = sweep;
                if (bus.brake) left_d = ALL_ON;
            end
            S_HAZARD: begin
                if (pos_q == POS_FULL) begin
                    left_d  = ALL_ON;
                    right_d = ALL_ON;
                end
            end
        endcase
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            pos_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            mode_q  <= 2'b00;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pos_q   <= pos_d;
            left_q  <= left_d;
            right_q <= right_d;
            mode_q  <= state_q;
            tick_q  <= step;
        end
    end

    assign bus.left_lamps  = left_q;
    assign bus.right_lamps = right_q;
    assign bus.mode        = mode_q;
    assign bus.tick        = tick_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// tb/tb_tail_light_seq.sv - self-checking bench for tail_light_seq

module tb_tail_light_seq;
    localparam int DIV_WIDTH = 5;
    localparam int DIV_MAX   = 3;
    localparam int LAMPS     = 3;

    logic clk;
    logic rst;

    tail_light_seq_if #(.LAMPS(LAMPS)) bus ();

    tail_light_seq #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX),
        .LAMPS     (LAMPS)
    ) dut (
        .ADC_CLK_10 (clk),
        .rst        (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a prescaler count plus a script of pending sweep
    // positions; an empty script means the lamps are between sweeps.
    int m_cnt  = 0;
    int m_mode = 0;
    int m_pos  = 0;
    int m_frames[$];
    logic [LAMPS-1:0] e_left  = '0;
    logic [LAMPS-1:0] e_right = '0;
    logic [1:0]       e_mode  = 2'b00;
    logic             e_tick  = 1'b0;

    task automatic model_edge();
        int full;
        int bar;
        if (rst) begin
            m_cnt = 0; m_mode = 0; m_pos = 0;
            m_frames.delete();
            e_left = '0; e_right = '0; e_mode = 2'b00; e_tick = 1'b0;
        end else begin
            full    = (1 << LAMPS) - 1;
            bar     = (1 << m_pos) - 1;
            e_mode  = 2'(m_mode);
            e_left  = '0;
            e_right = '0;
            if (m_mode == 0 && bus.brake) begin
                e_left = LAMPS'(full); e_right = LAMPS'(full);
            end else if (m_mode == 1) begin
                e_left = LAMPS'(bar);
                if (bus.brake) e_right = LAMPS'(full);
            end else if (m_mode == 2) begin
                e_right = LAMPS'(bar);
                if (bus.brake) e_left = LAMPS'(full);
            end else if (m_mode == 3 && m_pos == LAMPS) begin
                e_left = LAMPS'(full); e_right = LAMPS'(full);
            end
            e_tick = bus.en && (m_cnt == DIV_MAX);
            if (bus.en) begin
                if (m_cnt == DIV_MAX) begin
                    m_cnt = 0;
                    if (m_frames.size() == 0) begin
                        if (bus.hazard_req || (bus.left_req && bus.right_req)) begin
                            m_mode = 3;
                            m_frames.push_back(LAMPS);
                            m_frames.push_back(0);
                        end else if (bus.left_req || bus.right_req) begin
                            m_mode = bus.left_req ? 1 : 2;
                            for (int k = 1; k <= LAMPS; k++) m_frames.push_back(k);
                            m_frames.push_back(0);
                        end else begin
                            m_mode = 0;
                        end
                    end
                    if (m_frames.size() > 0) m_pos = m_frames.pop_front();
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic check_model();
        n_checks++;
        if (bus.left_lamps !== e_left || bus.right_lamps !== e_right ||
            bus.mode !== e_mode || bus.tick !== e_tick) begin
            n_fail++;
            $display("FAIL model @%0t: got L=%b R=%b mode=%b tick=%b, expected L=%b R=%b mode=%b tick=%b",
                     $time, bus.left_lamps, bus.right_lamps, bus.mode, bus.tick,
                     e_left, e_right, e_mode, e_tick);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic             rst;
        logic             en;
        logic             l;
        logic             r;
        logic             h;
        logic             b;
        int               n;
        logic [LAMPS-1:0] el;
        logic [LAMPS-1:0] er;
        logic [1:0]       em;
        logic             et;
    } vec_t;

    vec_t tbl[23];
    int   ticks;
    int   run;
    int   maxrun;

    initial begin
        // rst en  l  r  h  b   n   left    right   mode  tick
        tbl[0]  = '{1, 1, 1, 0, 0, 0,  2, 3'b000, 3'b000, 2'b00, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0,  4, 3'b000, 3'b000, 2'b00, 1};
        tbl[2]  = '{0, 1, 1, 0, 0, 0,  1, 3'b001, 3'b000, 2'b01, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 0,  4, 3'b011, 3'b000, 2'b01, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0,  4, 3'b111, 3'b000, 2'b01, 0};
        tbl[5]  = '{0, 1, 1, 0, 0, 0,  4, 3'b000, 3'b000, 2'b01, 0};
        tbl[6]  = '{0, 1, 1, 0, 0, 0,  4, 3'b001, 3'b000, 2'b01, 0};
        tbl[7]  = '{0, 1, 1, 0, 0, 0,  4, 3'b011, 3'b000, 2'b01, 0};
        tbl[8]  = '{0, 1, 0, 1, 0, 0,  4, 3'b111, 3'b000, 2'b01, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 0,  4, 3'b000, 3'b000, 2'b01, 0};
        tbl[10] = '{0, 1, 0, 1, 0, 0,  4, 3'b000, 3'b001, 2'b10, 0};
        tbl[11] = '{0, 1, 0, 1, 0, 1,  1, 3'b111, 3'b001, 2'b10, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 1,  3, 3'b111, 3'b011, 2'b10, 0};
        tbl[13] = '{0, 0, 0, 1, 0, 1, 10, 3'b111, 3'b011, 2'b10, 0};
        tbl[14] = '{0, 0, 0, 1, 0, 0,  1, 3'b000, 3'b011, 2'b10, 0};
        tbl[15] = '{1, 0, 0, 1, 0, 0,  1, 3'b000, 3'b000, 2'b00, 0};
        tbl[16] = '{0, 1, 1, 0, 1, 0,  4, 3'b000, 3'b000, 2'b00, 1};
        tbl[17] = '{0, 1, 1, 0, 1, 0,  1, 3'b111, 3'b111, 2'b11, 0};
        tbl[18] = '{0, 1, 1, 0, 0, 0,  4, 3'b000, 3'b000, 2'b11, 0};
        tbl[19] = '{0, 1, 1, 0, 0, 0,  4, 3'b001, 3'b000, 2'b01, 0};
        tbl[20] = '{0, 1, 0, 0, 0, 1, 16, 3'b111, 3'b111, 2'b00, 0};
        tbl[21] = '{0, 1, 0, 0, 1, 1,  8, 3'b000, 3'b000, 2'b11, 0};
        tbl[22] = '{0, 1, 1, 1, 0, 0,  4, 3'b111, 3'b111, 2'b11, 0};

        rst = 1'b1;
        bus.en = 1'b0; bus.left_req = 1'b0; bus.right_req = 1'b0;
        bus.hazard_req = 1'b0; bus.brake = 1'b0;

        // Directed scenarios with hand-derived expectations.
        for (int i = 0; i < 23; i++) begin
            rst            = tbl[i].rst;
            bus.en         = tbl[i].en;
            bus.left_req   = tbl[i].l;
            bus.right_req  = tbl[i].r;
            bus.hazard_req = tbl[i].h;
            bus.brake      = tbl[i].b;
            for (int c = 0; c < tbl[i].n; c++) clk1();
            chk($sformatf("vec%0d_left", i),  32'(bus.left_lamps),  32'(tbl[i].el));
            chk($sformatf("vec%0d_right", i), 32'(bus.right_lamps), 32'(tbl[i].er));
            chk($sformatf("vec%0d_mode", i),  32'(bus.mode),        32'(tbl[i].em));
            chk($sformatf("vec%0d_tick", i),  32'(bus.tick),        32'(tbl[i].et));
        end

        // Tick cadence: one single-cycle pulse every DIV_MAX+1 enabled clocks.
        rst = 1'b1;
        bus.left_req = 1'b0; bus.right_req = 1'b0; bus.hazard_req = 1'b0; bus.brake = 1'b0;
        clk1();
        rst = 1'b0; bus.en = 1'b1;
        ticks = 0; run = 0; maxrun = 0;
        for (int c = 0; c < 10 * (DIV_MAX + 1); c++) begin
            clk1();
            if (bus.tick === 1'b1) begin
                ticks++;
                run++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
        end
        chk("tick_count", 32'(ticks), 32'd10);
        chk("tick_width", 32'(maxrun), 32'd1);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            rst    = ($urandom_range(0, 299) == 0);
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) bus.left_req   = ~bus.left_req;
            if ($urandom_range(0, 19) == 0) bus.right_req  = ~bus.right_req;
            if ($urandom_range(0, 39) == 0) bus.hazard_req = ~bus.hazard_req;
            if ($urandom_range(0, 9)  == 0) bus.brake      = ~bus.brake;
            clk1();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
Parametrised sequential tail-light controller that generalises the board's single-pattern LED blinker. It drives N lamps per side and supports left-sweep, right-sweep, hazard and brake overlay. An internal prescaler sets the step rate. It sits between the switch/key inputs and LEDR; a small mode code is exported for the HEX decoder.

Parameters:
DIV_WIDTH, 5, width of prescaler counter
DIV_MAX, 31, prescaler terminal count; one tick every DIV_MAX+1 clocks (must fit DIV_WIDTH)
LAMPS, 3, lamps per side, legal range 1..8

Ports:
ADC_CLK_10  in  1  system clock
rst  in  1  reset, synchronous, active-high
en  in  1  prescaler enable; 0 freezes all sequencing
left_req  in  1  left turn request (level)
right_req  in  1  right turn request (level)
hazard_req  in  1  hazard request (level)
brake  in  1  brake pedal (level)
left_lamps  out  LAMPS  left lamps; bit0 innermost
right_lamps  out  LAMPS  right lamps; bit0 innermost
mode  out  2  current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD
tick  out  1  one-cycle step pulse

Behaviour:
- One clock, ADC_CLK_10. rst is synchronous, active-high and overrides every other input.
- Reset values: prescaler 0, state IDLE, pos 0, left_lamps 0, right_lamps 0, mode 00, tick 0.
- Prescaler: counts 0..DIV_MAX, then wraps to 0, only while en=1. tick=1 for exactly the cycle in which the count equals DIV_MAX and en=1.
- en=0: prescaler, state and pos hold; tick=0. Brake overlay still updates.
- Position pos has width clog2(LAMPS+1), range 0..LAMPS. pos=0 means the active side is blank.
- Requests are evaluated only on a tick while pos=0. Priority at evaluation:
  - hazard_req, or left_req and right_req together -> HAZARD.
  - else left_req -> LEFT.
  - else right_req -> RIGHT.
  - else -> IDLE.
  - Entering LEFT/RIGHT sets pos=1. Entering HAZARD sets pos=LAMPS. IDLE keeps pos=0.
- LEFT/RIGHT on each tick:
  - pos<LAMPS -> pos+1.
  - pos=LAMPS -> pos=0; state unchanged until the next evaluation.
  - Active side shows pattern (1<<pos)-1, so 001, 011, 111, 000 for LAMPS=3.
  - The other side is 0 unless brake is set.
- HAZARD on each tick: pos=LAMPS -> 0. pos=0 -> evaluation (reselecting HAZARD gives pos=LAMPS). Both sides show all-ones when pos=LAMPS and 0 otherwise. brake is ignored in HAZARD.
- Request withdrawn or changed mid-sweep: the current sweep completes to pos=0, then evaluation occurs on the next tick. There is no truncation and no glitch.
- Brake overlay: in IDLE both sides are all-ones. In LEFT, right_lamps is all-ones; in RIGHT, left_lamps is all-ones. The sequencing side is unaffected.
- All outputs are registered. Lamps and mode reflect state/pos/brake with 1-cycle latency after the updating edge.
- Assertion of rst mid-sequence: all outputs are 0 on the next edge, and the prescaler restarts from 0.

Test Plan:
- Reset with DIV_MAX=3: hold rst 2 clocks with left_req=1 -> lamps 0, mode 00; after release, first tick on the 4th clock; left_lamps=001 one clock after that tick.
- LAMPS=3, DIV_MAX=3, left_req held -> left_lamps steps 001, 011, 111, 000, 001 on successive ticks; right_lamps stays 000; mode 01.
- hazard_req and left_req both asserted in IDLE -> mode 11; both sides alternate 111/000 per tick. Drop hazard_req at 111 -> next tick 000, following tick LEFT 001.
- left sweep at 011, then switch to right_req only -> left shows 111, 000, then right_lamps 001 and mode 10.
- brake=1 during a right sweep -> left_lamps=111 one clock later while right_lamps keeps stepping. Brake in IDLE -> both 111. Brake in HAZARD -> no effect.
- en=0 for 10 clocks at pos 2 -> no tick, lamps frozen at 011. rst at pos 2 -> all outputs 0 next clock.
